// File: rtl/mailbox_target_if.sv
// Bus-side handshake bundle for the mailbox target: address phase, write
// data phase and read response/ack signals.
interface mailbox_target_if;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid;
  logic        target_rw;
  logic [7:0]  target_data_in;
  logic        target_data_in_valid;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;
  logic        target_ack;
  logic        target_ready;

  modport master (
    output target_addr_in, target_addr_in_valid, target_rw,
           target_data_in, target_data_in_valid,
    input  target_data_out, target_data_out_valid, target_ack, target_ready
  );

  modport slave (
    input  target_addr_in, target_addr_in_valid, target_rw,
           target_data_in, target_data_in_valid,
    output target_data_out, target_data_out_valid, target_ack, target_ready
  );
endinterface

// File: rtl/mailbox_target.sv
// Mailbox target: a 4-register bus slave bridging two byte FIFOs.
// RX carries bus writes to the local side, TX carries local pushes to bus
// reads. Sticky error flags record overflow, underflow and local drops.
module mailbox_target #(
  parameter int INTERNAL_ADDR_BITS = 11,
  parameter int DEPTH              = 8
) (
  input  logic       clk,
  input  logic       rst,
  mailbox_target_if.slave bus,
  input  logic       rx_pop,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       tx_push,
  input  logic [7:0] tx_data,
  output logic       tx_full
);

  localparam int         DATA_W  = 8;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, WDATA, WACK, RRESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] dout_q;

  logic              wr_en, rd_en;
  logic [1:0]        wr_sel, rd_sel;
  logic [DATA_W-1:0] wr_data, rd_data_d;
  logic              ready_c, ack_c, dvalid_c;

  // Storage is sized for the largest legal DEPTH so 4-bit pointers index it cleanly
  logic [DATA_W-1:0] rx_mem [0:15];
  logic [DATA_W-1:0] tx_mem [0:15];
  logic [3:0]        rx_wp_q, rx_rp_q, rx_cnt_q;
  logic [3:0]        tx_wp_q, tx_rp_q, tx_cnt_q;
  logic [2:0]        err_q, err_d;

  logic rx_full_c, tx_empty_c;
  logic rx_push_ok, rx_pop_ok, tx_push_ok, tx_pop_ok;
  logic rx_flush, tx_flush;
  logic rx_ovf_set, tx_unf_set, tx_drop_set, err_clr;

  // Only the register-select bits of the address are decoded
  logic unused_addr;
  assign unused_addr = ^{bus.target_addr_in[15:2], INTERNAL_ADDR_BITS[0]};

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == DEPTH_C - 4'd1) ? 4'd0 : p + 4'd1;
  endfunction

  // Bus FSM: next state, handshake outputs and register access strobes
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ready_c  = 1'b0;
    ack_c    = 1'b0;
    dvalid_c = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = sel_q;
    wr_data  = bus.target_data_in;
    rd_en    = 1'b0;
    rd_sel   = bus.target_addr_in[1:0];
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.target_addr_in_valid) begin
          if (bus.target_rw) begin
            sel_d = bus.target_addr_in[1:0];
            if (bus.target_data_in_valid) begin
              wr_en   = 1'b1;
              wr_sel  = bus.target_addr_in[1:0];
              state_d = WACK;
            end else begin
              state_d = WDATA;
            end
          end else begin
            rd_en   = 1'b1;
            state_d = RRESP;
          end
        end
      end
      WDATA: begin
        if (bus.target_data_in_valid) begin
          wr_en   = 1'b1;
          state_d = WACK;
        end
      end
      WACK: begin
        ack_c   = 1'b1;
        state_d = IDLE;
      end
      RRESP: begin
        ack_c    = 1'b1;
        dvalid_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.target_ready          = ready_c;
  assign bus.target_ack            = ack_c;
  assign bus.target_data_out_valid = dvalid_c;
  assign bus.target_data_out       = dvalid_c ? dout_q : '0;

  // FIFO and error-flag events decoded from the current bus and local requests
  always_comb begin
    rx_full_c   = (rx_cnt_q == DEPTH_C);
    tx_empty_c  = (tx_cnt_q == 4'd0);
    rx_flush    = wr_en && (wr_sel == 2'd2) && wr_data[0];
    tx_flush    = wr_en && (wr_sel == 2'd2) && wr_data[1];
    rx_push_ok  = wr_en && (wr_sel == 2'd0) && !rx_full_c;
    rx_ovf_set  = wr_en && (wr_sel == 2'd0) && rx_full_c;
    rx_pop_ok   = rx_pop && (rx_cnt_q != 4'd0) && !rx_flush;
    tx_pop_ok   = rd_en && (rd_sel == 2'd0) && !tx_empty_c;
    tx_unf_set  = rd_en && (rd_sel == 2'd0) && tx_empty_c;
    tx_push_ok  = tx_push && !tx_full && !tx_flush;
    tx_drop_set = tx_push && tx_full && !tx_flush;
    err_clr     = rd_en && (rd_sel == 2'd3);
    err_d       = (err_clr ? 3'b000 : err_q) | {tx_drop_set, rx_ovf_set, tx_unf_set};
  end

  // Read data captured at the accepting edge, before any pop it causes
  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      2'd0:    rd_data_d = tx_empty_c ? '0 : tx_mem[tx_rp_q];
      2'd1:    rd_data_d = {tx_cnt_q, rx_cnt_q};
      2'd3:    rd_data_d = {5'b00000, err_q};
      default: rd_data_d = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latched register select and read response data
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    if (rd_en) dout_q <= rd_data_d;
  end

  // RX FIFO pointers and occupancy; a flush overrides any same-cycle pop
  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wp_q  <= 4'd0;
      rx_rp_q  <= 4'd0;
      rx_cnt_q <= 4'd0;
    end else begin
      if (rx_push_ok) rx_wp_q <= ptr_inc(rx_wp_q);
      if (rx_pop_ok)  rx_rp_q <= ptr_inc(rx_rp_q);
      rx_cnt_q <= rx_cnt_q + 4'(rx_push_ok) - 4'(rx_pop_ok);
    end
  end

  // TX FIFO pointers and occupancy; a flush overrides any same-cycle push
  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wp_q  <= 4'd0;
      tx_rp_q  <= 4'd0;
      tx_cnt_q <= 4'd0;
    end else begin
      if (tx_push_ok) tx_wp_q <= ptr_inc(tx_wp_q);
      if (tx_pop_ok)  tx_rp_q <= ptr_inc(tx_rp_q);
      tx_cnt_q <= tx_cnt_q + 4'(tx_push_ok) - 4'(tx_pop_ok);
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp_q] <= wr_data;
    if (tx_push_ok) tx_mem[tx_wp_q] <= tx_data;
  end

  // Sticky error flags {tx_drop, rx_overflow, tx_underflow}
  always_ff @(posedge clk) begin
    if (rst) err_q <= 3'b000;
    else     err_q <= err_d;
  end

  assign rx_empty = (rx_cnt_q == 4'd0);
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp_q];
  assign tx_full  = (tx_cnt_q == DEPTH_C);

endmodule

// File: tb/tb_mailbox_target.sv
// Testbench for mailbox_target: directed scenarios followed by randomized
// bus/local traffic, scored against a queue-based reference model.
module tb_mailbox_target;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pop, tx_push;
  logic [7:0] tx_data, rx_data;
  logic       rx_empty, tx_full;

  always #5 clk = ~clk;

  mailbox_target_if bus_if ();

  mailbox_target #(.INTERNAL_ADDR_BITS(11), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit m_drop, m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Effect of one clock edge on the model, given every request active at it
  function automatic void model_edge(input bit lpop, input bit lpush, input logic [7:0] lpv,
                                     input bit wr, input logic [1:0] wa, input logic [7:0] wd,
                                     input bit rd, input logic [1:0] ra, output logic [7:0] rv);
    bit rx_full0 = (rxq.size() == DEPTH);
    bit tx_full0 = (txq.size() == DEPTH);
    bit rxfl = wr && wa == 2'd2 && wd[0];
    bit txfl = wr && wa == 2'd2 && wd[1];
    bit n_drop = 0, n_ovf = 0, n_unf = 0;
    logic [7:0] st = {4'(txq.size()), 4'(rxq.size())};
    rv = 8'h00;
    if (rd) begin
      case (ra)
        2'd0: if (txq.size() > 0) rv = txq.pop_front(); else n_unf = 1;
        2'd1: rv = st;
        2'd3: begin
          rv = {5'b0, m_drop, m_ovf, m_unf};
          m_drop = 0; m_ovf = 0; m_unf = 0;
        end
        default: rv = 8'h00;
      endcase
    end
    if (rxfl) rxq.delete();
    else begin
      if (lpop && rxq.size() > 0) void'(rxq.pop_front());
      if (wr && wa == 2'd0) begin
        if (!rx_full0) rxq.push_back(wd); else n_ovf = 1;
      end
    end
    if (txfl) txq.delete();
    else if (lpush) begin
      if (!tx_full0) txq.push_back(lpv); else n_drop = 1;
    end
    m_drop |= n_drop; m_ovf |= n_ovf; m_unf |= n_unf;
  endfunction

  task automatic check_local();
    check("rx_empty", rx_empty, rxq.size() == 0);
    check("rx_data", rx_data, rxq.size() > 0 ? rxq[0] : 8'h00);
    check("tx_full", tx_full, txq.size() == DEPTH);
  endtask

  task automatic clear_inputs();
    bus_if.target_addr_in_valid = 0;
    bus_if.target_rw            = 0;
    bus_if.target_data_in_valid = 0;
    bus_if.target_data_in       = 8'h00;
    bus_if.target_addr_in       = 16'h0000;
    rx_pop  = 0;
    tx_push = 0;
    tx_data = 8'h00;
  endtask

  task automatic do_reset(input int n);
    clear_inputs();
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
    rxq.delete(); txq.delete();
    m_drop = 0; m_ovf = 0; m_unf = 0;
    check("rst_ready", bus_if.target_ready, 1);
    check("rst_ack", bus_if.target_ack, 0);
    check("rst_dvalid", bus_if.target_data_out_valid, 0);
    check("rst_dout", bus_if.target_data_out, 0);
    check_local();
  endtask

  // Bus write; gap = idle cycles between address and data phases
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int gap,
                           input bit lpop, input bit lpush, input logic [7:0] lpv);
    logic [7:0] dummy;
    check_local();
    check("wr_ready", bus_if.target_ready, 1);
    bus_if.target_addr_in       = {14'($urandom), a};
    bus_if.target_addr_in_valid = 1;
    bus_if.target_rw            = 1;
    for (int i = 0; i <= gap; i++) begin
      if (i == gap) begin
        bus_if.target_data_in_valid = 1;
        bus_if.target_data_in       = d;
        rx_pop = lpop; tx_push = lpush; tx_data = lpv;
        model_edge(lpop, lpush, lpv, 1, a, d, 0, 2'd0, dummy);
      end
      @(negedge clk);
      clear_inputs();
      if (i < gap) begin
        check("wdata_ack", bus_if.target_ack, 0);
        check("wdata_ready", bus_if.target_ready, 0);
        // Address strobes while waiting for data must be ignored
        bus_if.target_addr_in_valid = 1'($urandom);
        bus_if.target_rw            = 1'($urandom);
        bus_if.target_addr_in       = 16'($urandom);
      end
    end
    check("wr_ack", bus_if.target_ack, 1);
    check("wr_dvalid", bus_if.target_data_out_valid, 0);
    @(negedge clk);
    check("wr_ack_end", bus_if.target_ack, 0);
  endtask

  task automatic bus_read(input logic [1:0] a, input bit lpush, input logic [7:0] lpv,
                          output logic [7:0] got);
    logic [7:0] exp;
    check_local();
    check("rd_ready", bus_if.target_ready, 1);
    bus_if.target_addr_in       = {14'($urandom), a};
    bus_if.target_addr_in_valid = 1;
    bus_if.target_rw            = 0;
    tx_push = lpush; tx_data = lpv;
    model_edge(0, lpush, lpv, 0, 2'd0, 8'h00, 1, a, exp);
    @(negedge clk);
    clear_inputs();
    got = bus_if.target_data_out;
    check("rd_dvalid", bus_if.target_data_out_valid, 1);
    check("rd_ack", bus_if.target_ack, 1);
    check("rd_data", bus_if.target_data_out, exp);
    @(negedge clk);
    check("rd_dvalid_end", bus_if.target_data_out_valid, 0);
    check("rd_dout_zero", bus_if.target_data_out, 0);
    check("rd_ready_end", bus_if.target_ready, 1);
  endtask

  task automatic local_op(input bit lpop, input bit lpush, input logic [7:0] lpv);
    logic [7:0] dummy;
    check_local();
    rx_pop = lpop; tx_push = lpush; tx_data = lpv;
    model_edge(lpop, lpush, lpv, 0, 2'd0, 8'h00, 0, 2'd0, dummy);
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    logic [7:0] got;
    clear_inputs();
    rst = 1;
    @(negedge clk);

    // Reset state and empty STATUS
    do_reset(3);
    bus_read(2'd1, 0, 8'h00, got);
    check("status_after_reset", got, 8'h00);

    // Bus write with data one cycle after address, then local drain
    bus_write(2'd0, 8'hA7, 1, 0, 0, 8'h00);
    check("rx_head_a7", rx_data, 8'hA7);
    check("rx_not_empty", rx_empty, 0);
    local_op(1, 0, 8'h00);
    check("rx_empty_after_pop", rx_empty, 1);

    // Local TX fill, bus drain including underflow, ERR clear-on-read
    local_op(0, 1, 8'h5E);
    local_op(0, 1, 8'h3C);
    bus_read(2'd0, 0, 8'h00, got); check("tx_rd0", got, 8'h5E);
    bus_read(2'd0, 0, 8'h00, got); check("tx_rd1", got, 8'h3C);
    bus_read(2'd0, 0, 8'h00, got); check("tx_rd_empty", got, 8'h00);
    bus_read(2'd3, 0, 8'h00, got); check("err_unf", got, 8'h01);
    bus_read(2'd3, 0, 8'h00, got); check("err_cleared", got, 8'h00);

    // RX overflow
    for (int i = 0; i < 8; i++) bus_write(2'd0, 8'(i), 0, 0, 0, 8'h00);
    bus_write(2'd0, 8'hFF, 0, 0, 0, 8'h00);
    bus_read(2'd1, 0, 8'h00, got); check("status_rx_full", got, 8'h08);
    bus_read(2'd3, 0, 8'h00, got); check("err_ovf", got, 8'h02);
    for (int i = 0; i < 8; i++) begin
      check("rx_order", rx_data, 8'(i));
      local_op(1, 0, 8'h00);
    end
    check("rx_drained", rx_empty, 1);

    // Simultaneous bus push and local pop on RX
    bus_write(2'd0, 8'h11, 0, 0, 0, 8'h00);
    bus_write(2'd0, 8'h22, 2, 0, 0, 8'h00);
    bus_write(2'd0, 8'h33, 0, 0, 0, 8'h00);
    bus_write(2'd0, 8'h44, 0, 1, 0, 8'h00);
    bus_read(2'd1, 0, 8'h00, got); check("status_rx3", got, 8'h03);
    check("rx_head_22", rx_data, 8'h22);
    for (int i = 0; i < 3; i++) local_op(1, 0, 8'h00);

    // TX full: local drop, ERR read racing a new drop, flush beating local ops
    for (int i = 0; i < 9; i++) local_op(0, 1, 8'(8'h80 + i));
    bus_read(2'd3, 1, 8'hEE, got); check("err_drop_old", got, 8'h04);
    bus_read(2'd3, 0, 8'h00, got); check("err_drop_new", got, 8'h04);
    bus_write(2'd0, 8'h55, 0, 0, 0, 8'h00);
    bus_write(2'd2, 8'h03, 1, 1, 1, 8'h77);
    bus_read(2'd1, 0, 8'h00, got); check("status_flushed", got, 8'h00);
    bus_read(2'd3, 0, 8'h00, got); check("err_after_flush", got, 8'h00);

    // Reset while waiting for write data
    bus_write(2'd0, 8'h66, 0, 0, 0, 8'h00);
    bus_if.target_addr_in       = 16'h0000;
    bus_if.target_addr_in_valid = 1;
    bus_if.target_rw            = 1;
    @(negedge clk);
    clear_inputs();
    rst = 1;
    bus_if.target_data_in_valid = 1;
    bus_if.target_data_in       = 8'h99;
    @(negedge clk);
    clear_inputs();
    rst = 0;
    rxq.delete(); txq.delete();
    m_drop = 0; m_ovf = 0; m_unf = 0;
    check("rst_wdata_ack", bus_if.target_ack, 0);
    check("rst_wdata_ready", bus_if.target_ready, 1);
    @(negedge clk);
    check("rst_wdata_ack2", bus_if.target_ack, 0);
    bus_read(2'd1, 0, 8'h00, got); check("rst_wdata_status", got, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int op = int'($urandom_range(0, 6));
      case (op)
        0, 1: bus_write(2'd0, 8'($urandom), int'($urandom_range(0, 2)),
                        1'($urandom), 1'($urandom), 8'($urandom));
        2: bus_read(2'($urandom), 1'($urandom), 8'($urandom), got);
        3: local_op(1, 1'($urandom), 8'($urandom));
        4: local_op(1'($urandom), 1, 8'($urandom));
        5: bus_write(($urandom_range(0, 3) == 0) ? 2'd2 : 2'd3, 8'($urandom),
                     int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 8'($urandom));
        default: bus_write(2'd1, 8'($urandom), 0, 0, 1, 8'($urandom));
      endcase
    end
    bus_read(2'd1, 0, 8'h00, got);
    bus_read(2'd3, 0, 8'h00, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
